alu_seq: RTL and testbench
==========================

# alu_seq

Command sequencer that sits directly upstream of the 8-bit ALU and also captures what the ALU produces. It accepts operation commands over a valid/ready handshake and drives the ALU's operand and control inputs from internal registers. It iterates shift/rotate operations a programmable number of times, then registers the result with carry and zero flags behind a valid/ready output. A result accumulator lets successive commands chain without re-supplying operand a.

## Interface
- ACC_RESET, 8'h00, accumulator value after reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 rotate left, 101 rotate right, 110 shift left logical, 111 shift right logical.
- cmd_sel  in  1  shift ops only: 0 operates on a, 1 operates on b.
- cmd_cnt  in  3  shift ops only: iteration count; 0 means 8.
- cmd_acc  in  1  1 = use accumulator as operand a, ignoring cmd_a.
- cmd_a, cmd_b  in  8 each  operands.
- alu_a, alu_b  out  8 each  ALU operand inputs.
- alu_op  out  3  ALU ctrl_op input.
- alu_in  out  1  ALU ctrl_in input.
- alu_out  in  8  ALU result.
- alu_carry  in  1  ALU carry; meaningful for add only, 0 otherwise.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  result.
- res_carry  out  1  carry flag from the ALU on the final step.
- res_zero  out  1  1 when res_data == 8'h00.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch the following and go to EXEC:
    - op_a = cmd_acc ? acc : cmd_a; op_b = cmd_b.
    - op, sel.
    - iter = (cmd_cnt == 0) ? 8 : cmd_cnt.
- EXEC:
  - alu_a = op_a, alu_b = op_b, alu_op = op, alu_in = sel. All are registered, so the ALU path is purely combinational through the ALU.
  - Ops 000–011: capture res_data = alu_out and res_carry = alu_carry, then go to DONE.
  - Ops 100–111:
    - Each cycle, write alu_out back into op_a (sel = 0) or op_b (sel = 1) and decrement iter.
    - On the cycle where iter == 1, capture res_data = alu_out and res_carry = alu_carry (0 for shifts), then go to DONE.
- DONE:
  - res_valid = 1; res_data, res_carry and res_zero are held stable.
  - On res_ready, load acc = res_data and go to IDLE.
- cmd_ready = 0 in EXEC and DONE. cmd_valid is ignored there; no command is buffered.
- Arithmetic is modulo 256. Sub borrow is not reported; res_carry = 0 for sub.
- res_zero is computed from the registered res_data, not from alu_out.

## Timing
- Reset values:
  - state IDLE, acc = ACC_RESET.
  - alu_a, alu_b = 8'h00; alu_op = 3'b000; alu_in = 0.
  - res_valid = 0, res_data = 8'h00, res_carry = 0, res_zero = 1.
  - cmd_ready = 0 while rst_n is low.
- Latency, with the command accepted on edge T:
  - ops 000–011: res_valid high after edge T+2.
  - shift ops with n iterations: res_valid high after edge T+1+n (n = 8 gives T+9).
- Result handshake completes on the edge where res_valid && res_ready. cmd_ready rises the next cycle, so back-to-back commands cost one IDLE cycle.
- res_ready held high before DONE has no effect.
- Reset mid-EXEC or mid-DONE: the command is abandoned, no result is produced, and all registers take their reset values on that edge.
- The accumulator updates only on a result handshake. A command that uses cmd_acc = 1 immediately after a handshake sees the new acc.

## Test plan
- Add with carry: a = F0, b = 20, op 000 → res_data 10, res_carry 1, res_zero 0; res_valid two edges after accept.
- Sub to zero: a = 05, b = 05, op 001 → res_data 00, res_zero 1, res_carry 0.
- Rotate left on a: a = 81, op 100, sel 0, cnt 3 → alu_a sequence 81, 03, 06; res_data 0C; res_valid four edges after accept.
- Shift right on b: b = FF, op 111, sel 1, cnt 0 → eight iterations, res_data 00, res_zero 1, res_valid nine edges after accept.
- Accumulator chain: 01 + 01 (op 000), then cmd_acc = 1, b = 03, op 010 → second res_data 02; cmd_a value on the second command is ignored.
- Backpressure and reset:
  - Hold res_ready = 0 for 5 cycles in DONE: res_data is stable and cmd_ready stays 0 despite cmd_valid = 1.
  - Then assert rst_n = 0 during a cnt 5 shift: on the next edge res_valid = 0, acc = ACC_RESET, and cmd_ready = 1 one cycle after release.

Source files
------------

// File: rtl/alu_seq_if.sv
// Command and result handshake bundle between a command source and alu_seq.
// master: command producer / result consumer. slave: the sequencer.
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_sel;
    logic [2:0] cmd_cnt;
    logic       cmd_acc;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_cnt, cmd_acc, cmd_a, cmd_b,
        input  cmd_ready,
        input  res_valid, res_data, res_carry, res_zero,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_cnt, cmd_acc, cmd_a, cmd_b,
        output cmd_ready,
        output res_valid, res_data, res_carry, res_zero,
        input  res_ready
    );
endinterface

// File: rtl/alu_seq.sv
// Command sequencer in front of an 8-bit combinational ALU. Latches a command,
// drives registered ALU inputs, iterates shift/rotate ops, and holds the
// result with carry/zero flags until the consumer takes it. Results feed an
// accumulator that later commands may use as operand a.
module alu_seq #(
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] acc;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] op;
    logic       sel;
    logic [3:0] iter;
    logic       primed;
    logic [7:0] res_data_q;
    logic       res_carry_q;

    logic       accept;
    logic       capture;
    logic       handshake;
    logic       cmd_ready_c;
    logic       res_valid_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;
        cmd_ready_c = 1'b0;
        res_valid_c = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = rst_n;
                if (bus.cmd_valid && cmd_ready_c) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Logic ops finish on their first working cycle; shift ops
                // finish on the cycle where one iteration remains.
                if (primed && (!op[2] || iter == 4'd1)) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, ALU input registers, iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= ACC_RESET;
            op_a        <= '0;
            op_b        <= '0;
            op          <= '0;
            sel         <= 1'b0;
            iter        <= '0;
            primed      <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_in      <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= bus.cmd_acc ? acc : bus.cmd_a;
                op_b   <= bus.cmd_b;
                op     <= bus.cmd_op;
                sel    <= bus.cmd_sel;
                iter   <= (bus.cmd_cnt == 3'd0) ? 4'd8 : {1'b0, bus.cmd_cnt};
                primed <= 1'b0;
            end
            if (state == EXEC) begin
                if (!primed) begin
                    // First EXEC cycle loads the ALU input registers; the
                    // ALU registers then act as the working operands, so the
                    // shift write-back lands directly on the selected one.
                    alu_a  <= op_a;
                    alu_b  <= op_b;
                    alu_op <= op;
                    alu_in <= sel;
                    primed <= 1'b1;
                end else if (capture) begin
                    res_data_q  <= alu_out;
                    res_carry_q <= alu_carry;
                end else begin
                    if (sel) begin
                        alu_b <= alu_out;
                    end else begin
                        alu_a <= alu_out;
                    end
                    iter <= iter - 4'd1;
                end
            end
            if (handshake) begin
                acc <= res_data_q;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = (res_data_q == 8'h00);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU attached.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_in;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic [7:0] shv;
    logic [8:0] sum9;

    int checks = 0;
    int errors = 0;
    int lat;

    alu_seq_if bus_if ();

    alu_seq #(.ACC_RESET(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_in    (alu_in),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: single-step shifts act on a (ctrl_in=0) or b (ctrl_in=1).
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b};
        shv       = alu_in ? alu_b : alu_a;
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            3'b000: begin alu_out = sum9[7:0]; alu_carry = sum9[8]; end
            3'b001: alu_out = alu_a - alu_b;
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = {shv[6:0], shv[7]};
            3'b101: alu_out = {shv[0], shv[7:1]};
            3'b110: alu_out = {shv[6:0], 1'b0};
            default: alu_out = {1'b0, shv[7:1]};
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic sel, input logic [2:0] cnt,
                         input logic use_acc, input logic [7:0] a, input logic [7:0] b);
        chk("cmd_ready_before_accept", 32'(bus_if.cmd_ready), 32'd1);
        bus_if.cmd_op    = op;
        bus_if.cmd_sel   = sel;
        bus_if.cmd_cnt   = cnt;
        bus_if.cmd_acc   = use_acc;
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        bus_if.cmd_valid = 1'b1;
        step();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int edges);
        edges = 0;
        while (bus_if.res_valid !== 1'b1 && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic take_res;
        bus_if.res_ready = 1'b1;
        step();
        bus_if.res_ready = 1'b0;
        chk("res_valid_after_handshake", 32'(bus_if.res_valid), 32'd0);
        chk("cmd_ready_after_handshake", 32'(bus_if.cmd_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = '0;
        bus_if.cmd_sel   = 1'b0;
        bus_if.cmd_cnt   = '0;
        bus_if.cmd_acc   = 1'b0;
        bus_if.cmd_a     = '0;
        bus_if.cmd_b     = '0;
        bus_if.res_ready = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus_if.res_data), 32'h00);
        chk("rst_res_carry", 32'(bus_if.res_carry), 32'd0);
        chk("rst_res_zero", 32'(bus_if.res_zero), 32'd1);
        chk("rst_alu_a", 32'(alu_a), 32'h00);
        chk("rst_alu_b", 32'(alu_b), 32'h00);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_in", 32'(alu_in), 32'd0);
        rst_n = 1'b1;
        step();
        chk("cmd_ready_after_rst", 32'(bus_if.cmd_ready), 32'd1);

        // Add with carry: F0 + 20
        issue(3'b000, 1'b0, 3'd0, 1'b0, 8'hF0, 8'h20);
        wait_res(lat);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_data", 32'(bus_if.res_data), 32'h10);
        chk("add_carry", 32'(bus_if.res_carry), 32'd1);
        chk("add_zero", 32'(bus_if.res_zero), 32'd0);
        take_res();

        // Sub to zero: 05 - 05
        issue(3'b001, 1'b0, 3'd0, 1'b0, 8'h05, 8'h05);
        wait_res(lat);
        chk("sub_latency", 32'(lat), 32'd2);
        chk("sub_data", 32'(bus_if.res_data), 32'h00);
        chk("sub_zero", 32'(bus_if.res_zero), 32'd1);
        chk("sub_carry", 32'(bus_if.res_carry), 32'd0);
        take_res();

        // Rotate left a=81, cnt 3: alu_a 81, 03, 06; result 0C
        issue(3'b100, 1'b0, 3'd3, 1'b0, 8'h81, 8'h00);
        step();
        chk("rol_alu_a_0", 32'(alu_a), 32'h81);
        chk("rol_alu_op", 32'(alu_op), 32'd4);
        step();
        chk("rol_alu_a_1", 32'(alu_a), 32'h03);
        step();
        chk("rol_alu_a_2", 32'(alu_a), 32'h06);
        chk("rol_not_yet_valid", 32'(bus_if.res_valid), 32'd0);
        step();
        chk("rol_valid_t4", 32'(bus_if.res_valid), 32'd1);
        chk("rol_data", 32'(bus_if.res_data), 32'h0C);
        chk("rol_carry", 32'(bus_if.res_carry), 32'd0);
        take_res();

        // Shift right b=FF, cnt 0 (eight iterations)
        issue(3'b111, 1'b1, 3'd0, 1'b0, 8'h00, 8'hFF);
        wait_res(lat);
        chk("shr8_latency", 32'(lat), 32'd9);
        chk("shr8_data", 32'(bus_if.res_data), 32'h00);
        chk("shr8_zero", 32'(bus_if.res_zero), 32'd1);
        chk("shr8_alu_in", 32'(alu_in), 32'd1);
        take_res();

        // Accumulator chain: 01 + 01 = 02, then acc & 03 with cmd_a ignored
        issue(3'b000, 1'b0, 3'd0, 1'b0, 8'h01, 8'h01);
        wait_res(lat);
        chk("chain1_data", 32'(bus_if.res_data), 32'h02);
        take_res();
        issue(3'b010, 1'b0, 3'd0, 1'b1, 8'hFF, 8'h03);
        wait_res(lat);
        chk("chain2_latency", 32'(lat), 32'd2);
        chk("chain2_data", 32'(bus_if.res_data), 32'h02);
        take_res();

        // Backpressure: A5 | 0F held in DONE for five cycles
        issue(3'b011, 1'b0, 3'd0, 1'b0, 8'hA5, 8'h0F);
        wait_res(lat);
        chk("or_data", 32'(bus_if.res_data), 32'hAF);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_a     = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res_valid", 32'(bus_if.res_valid), 32'd1);
            chk("bp_res_data", 32'(bus_if.res_data), 32'hAF);
            chk("bp_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        end
        bus_if.cmd_valid = 1'b0;
        take_res();

        // Reset during a cnt 5 shift (acc holds AF before this)
        issue(3'b110, 1'b0, 3'd5, 1'b0, 8'h01, 8'h00);
        step();
        step();
        chk("shl_mid_alu_a", 32'(alu_a), 32'h02);
        rst_n = 1'b0;
        chk("rst_mid_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        step();
        chk("rst_mid_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("rst_mid_alu_a", 32'(alu_a), 32'h00);
        chk("rst_mid_res_zero", 32'(bus_if.res_zero), 32'd1);
        chk("rst_mid_cmd_ready_low", 32'(bus_if.cmd_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("cmd_ready_after_rst2", 32'(bus_if.cmd_ready), 32'd1);

        // Accumulator back at 00: acc + 07 = 07; res_ready held high beforehand
        bus_if.res_ready = 1'b1;
        issue(3'b000, 1'b0, 3'd0, 1'b1, 8'hFF, 8'h07);
        wait_res(lat);
        chk("acc_rst_latency", 32'(lat), 32'd2);
        chk("acc_rst_data", 32'(bus_if.res_data), 32'h07);
        chk("acc_rst_carry", 32'(bus_if.res_carry), 32'd0);
        step();
        bus_if.res_ready = 1'b0;
        chk("early_ready_done", 32'(bus_if.res_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
